// File: rtl/pmci_vdm_tx_sequencer_pkg.sv
// Shared constants for the PMCI VDM TX sequencer: FSM state codes, FCR field
// positions and the default VDM register window offsets.
package pmci_vdm_seq_pkg;

   localparam int unsigned FCR_COMMIT_BIT = 31;
   localparam int unsigned FCR_LEN_LSB    = 0;
   localparam int unsigned FCR_LEN_MSB    = 15;

   localparam logic [17:0] FCR_ADDR_DEF = 18'h2000;
   localparam logic [17:0] DR_ADDR_DEF  = 18'h2008;

   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE      = 3'd0;
   localparam state_t ST_COLLECT   = 3'd1;
   localparam state_t ST_DROP      = 3'd2;
   localparam state_t ST_POLL_RD   = 3'd3;
   localparam state_t ST_POLL_WAIT = 3'd4;
   localparam state_t ST_GAP       = 3'd5;
   localparam state_t ST_WR_DATA   = 3'd6;
   localparam state_t ST_COMMIT    = 3'd7;

   function automatic logic [31:0] fcr_commit_word(input logic [15:0] len);
      logic [31:0] w;
      w = '0;
      w[FCR_COMMIT_BIT] = 1'b1;
      w[FCR_LEN_MSB:FCR_LEN_LSB] = len;
      return w;
   endfunction

endpackage

// File: rtl/pmci_vdm_tx_sequencer_if.sv
// Stream sink + AVMM master bundle of the VDM TX sequencer.
interface pmci_vdm_tx_sequencer_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 18
);
   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] s_data;
   logic              s_sop;
   logic              s_eop;
   logic [ADDR_W-1:0] m_address;
   logic              m_write;
   logic              m_read;
   logic [DATA_W-1:0] m_writedata;
   logic [DATA_W-1:0] m_readdata;
   logic              m_readdatavalid;
   logic              m_waitrequest;

   modport master (
      input  s_valid, s_data, s_sop, s_eop, m_readdata, m_readdatavalid, m_waitrequest,
      output s_ready, m_address, m_write, m_read, m_writedata
   );

   modport slave (
      output s_valid, s_data, s_sop, s_eop, m_readdata, m_readdatavalid, m_waitrequest,
      input  s_ready, m_address, m_write, m_read, m_writedata
   );
endinterface

// File: rtl/pmci_vdm_pkt_buf.sv
// Single-packet dword buffer: pointer-based writes, registered read that
// always presents the word at the next read pointer.
module pmci_vdm_pkt_buf #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic              wr_restart,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_clr,
   input  logic              rd_adv,
   output logic [DATA_W-1:0] rd_data
);
   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, wr_addr, rd_ptr, rd_ptr_nxt;

   always_comb begin
      wr_addr    = wr_restart ? '0 : wr_ptr;
      rd_ptr_nxt = rd_clr ? '0 : (rd_adv ? rd_ptr + PTR_W'(1) : rd_ptr);
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Reading at rd_ptr_nxt keeps rd_data one step ahead, so data is valid
   // in the same cycle the write strobe goes out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         rd_data <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_addr + PTR_W'(1);
         rd_ptr  <= rd_ptr_nxt;
         rd_data <= mem[rd_ptr_nxt];
      end
   end
endmodule

// File: rtl/pmci_vdm_tx_sequencer.sv
// Buffers one MCTP packet and pushes it through the PMCI VDM TX mailbox.
// Build option: PMCI_VDM_TX_SEQ_STATS_EN enables pkt_count/drop_count.
module pmci_vdm_tx_sequencer
   import pmci_vdm_seq_pkg::*;
#(
   parameter int unsigned       DATA_W        = 32,
   parameter int unsigned       ADDR_W        = 18,
   parameter logic [ADDR_W-1:0] FCR_ADDR      = ADDR_W'(FCR_ADDR_DEF),
   parameter logic [ADDR_W-1:0] DR_ADDR       = ADDR_W'(DR_ADDR_DEF),
   parameter int unsigned       MAX_PKT_DW    = 64,
   parameter int unsigned       POLL_GAP      = 16,
   parameter int unsigned       TIMEOUT_POLLS = 256
) (
   input  logic                     clk,
   input  logic                     rst_n,
   pmci_vdm_tx_sequencer_if.master  bus,
   output logic                     busy,
   output logic                     pkt_done,
   output logic                     err_timeout,
   output logic                     err_len,
   output logic [15:0]              pkt_count,
   output logic [15:0]              drop_count
);
   localparam int unsigned LEN_W  = $clog2(MAX_PKT_DW) + 1;
   localparam int unsigned GAP_W  = $clog2(POLL_GAP + 1);
   localparam int unsigned POLL_W = $clog2(TIMEOUT_POLLS + 1);

   state_t            state, state_nxt;
   logic [LEN_W-1:0]  len, wr_cnt;
   logic [POLL_W-1:0] poll_cnt;
   logic [GAP_W-1:0]  gap_cnt;
   logic              ready_en, rdy, accept, enough;
   logic              buf_wr, buf_restart, rd_clr, rd_adv;
   logic [DATA_W-1:0] rd_data;

   pmci_vdm_pkt_buf #(.DATA_W(DATA_W), .DEPTH(MAX_PKT_DW)) u_buf (
      .clk(clk), .rst_n(rst_n), .wr_en(buf_wr), .wr_restart(buf_restart),
      .wr_data(bus.s_data), .rd_clr(rd_clr), .rd_adv(rd_adv), .rd_data(rd_data)
   );

   always_comb begin
      rdy    = ready_en && (state == ST_IDLE || state == ST_COLLECT || state == ST_DROP);
      accept = bus.s_valid && rdy;
      enough = bus.m_readdata[FCR_LEN_MSB:FCR_LEN_LSB] >= 16'(len);
      busy   = (state != ST_IDLE);
   end

   always_comb begin
      state_nxt       = state;
      buf_wr          = 1'b0;
      buf_restart     = 1'b0;
      rd_clr          = 1'b0;
      rd_adv          = 1'b0;
      err_len         = 1'b0;
      err_timeout     = 1'b0;
      pkt_done        = 1'b0;
      bus.s_ready     = rdy;
      bus.m_read      = 1'b0;
      bus.m_write     = 1'b0;
      bus.m_address   = '0;
      bus.m_writedata = '0;
      case (state)
         ST_IDLE: if (accept && bus.s_sop) begin
            buf_wr      = 1'b1;
            buf_restart = 1'b1;
            state_nxt   = bus.s_eop ? ST_POLL_RD : ST_COLLECT;
         end
         ST_COLLECT: if (accept) begin
            buf_wr = 1'b1;
            if (bus.s_sop) begin
               buf_restart = 1'b1;
               err_len     = 1'b1;
               if (bus.s_eop) state_nxt = ST_POLL_RD;
            end else if (bus.s_eop) begin
               state_nxt = ST_POLL_RD;
            end else if (len == LEN_W'(MAX_PKT_DW - 1)) begin
               err_len   = 1'b1;
               state_nxt = ST_DROP;
            end
         end
         ST_DROP: if (accept && bus.s_eop) state_nxt = ST_IDLE;
         ST_POLL_RD: begin
            bus.m_read    = 1'b1;
            bus.m_address = FCR_ADDR;
            if (!bus.m_waitrequest) state_nxt = ST_POLL_WAIT;
         end
         ST_POLL_WAIT: if (bus.m_readdatavalid) begin
            if (enough) begin
               rd_clr    = 1'b1;
               state_nxt = ST_WR_DATA;
            end else if (poll_cnt == POLL_W'(TIMEOUT_POLLS - 1)) begin
               err_timeout = 1'b1;
               state_nxt   = ST_IDLE;
            end else begin
               state_nxt = ST_GAP;
            end
         end
         ST_GAP: if (gap_cnt == GAP_W'(POLL_GAP - 1)) state_nxt = ST_POLL_RD;
         ST_WR_DATA: begin
            bus.m_write     = 1'b1;
            bus.m_address   = DR_ADDR;
            bus.m_writedata = rd_data;
            if (!bus.m_waitrequest) begin
               rd_adv = 1'b1;
               if (wr_cnt == len - LEN_W'(1)) state_nxt = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            bus.m_write     = 1'b1;
            bus.m_address   = FCR_ADDR;
            bus.m_writedata = DATA_W'(fcr_commit_word(16'(len)));
            if (!bus.m_waitrequest) begin
               pkt_done  = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         ready_en <= 1'b0;
         len      <= '0;
         wr_cnt   <= '0;
         poll_cnt <= '0;
         gap_cnt  <= '0;
      end else begin
         state    <= state_nxt;
         ready_en <= 1'b1;
         if (buf_wr) len <= buf_restart ? LEN_W'(1) : len + LEN_W'(1);
         if (state == ST_IDLE || state == ST_COLLECT) poll_cnt <= '0;
         else if (state == ST_POLL_WAIT && bus.m_readdatavalid && !enough)
            poll_cnt <= poll_cnt + POLL_W'(1);
         gap_cnt <= (state == ST_GAP) ? gap_cnt + GAP_W'(1) : '0;
         if (rd_clr) wr_cnt <= '0;
         else if (rd_adv) wr_cnt <= wr_cnt + LEN_W'(1);
      end
   end

`ifdef PMCI_VDM_TX_SEQ_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pkt_count  <= '0;
         drop_count <= '0;
      end else begin
         if (pkt_done && pkt_count != '1) pkt_count <= pkt_count + 16'd1;
         if ((err_len || err_timeout) && drop_count != '1) drop_count <= drop_count + 16'd1;
      end
   end
`else
   always_comb begin
      pkt_count  = '0;
      drop_count = '0;
   end
`endif
endmodule

// File: tb/tb_pmci_vdm_tx_sequencer.sv
// Directed + randomized bench for pmci_vdm_tx_sequencer with a packet-level
// framing model and a reactive AVMM slave answering FCR polls.
module tb_pmci_vdm_tx_sequencer;
   localparam int unsigned POLL_GAP      = 16;
   localparam int unsigned TIMEOUT_POLLS = 256;
   localparam int unsigned MAX_PKT_DW    = 64;
   localparam logic [17:0] FCR = 18'h2000;
   localparam logic [17:0] DR  = 18'h2008;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pmci_vdm_tx_sequencer_if #(.DATA_W(32), .ADDR_W(18)) bus ();
   logic        busy, pkt_done, err_timeout, err_len;
   logic [15:0] pkt_count, drop_count;

   pmci_vdm_tx_sequencer #(
      .DATA_W(32), .ADDR_W(18), .FCR_ADDR(FCR), .DR_ADDR(DR),
      .MAX_PKT_DW(MAX_PKT_DW), .POLL_GAP(POLL_GAP), .TIMEOUT_POLLS(TIMEOUT_POLLS)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .pkt_done(pkt_done),
      .err_timeout(err_timeout), .err_len(err_len),
      .pkt_count(pkt_count), .drop_count(drop_count)
   );

   typedef struct { logic [31:0] data; bit sop; bit eop; } beat_t;
   typedef struct { logic [17:0] addr; logic [31:0] data; int unsigned cyc; } wr_t;

   int unsigned tests = 0;
   int unsigned fails = 0;
   int unsigned cyc = 0;
   wr_t         wr_log[$];
   int unsigned rd_log[$], rdv_log[$], rsp_q[$], acc_log[$];
   logic [31:0] fcr_q[$];
   logic [31:0] fcr_default = 32'h0000_FFFF;
   beat_t       stim[$];
   int unsigned done_n = 0, tmo_n = 0, len_n = 0, done_cyc = 0, len_cyc = 0;
   int unsigned exp_pkt = 0, exp_drop = 0;
   bit          stall_en = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] stat(input int unsigned v);
`ifdef PMCI_VDM_TX_SEQ_STATS_EN
      return (v > 32'hFFFF) ? 16'hFFFF : 16'(v);
`else
      return 16'(v * 0);
`endif
   endfunction

   // Packet framing rules applied to a beat list: which packet (if any) is
   // transmitted and how many length errors the stream produces.
   function automatic void frame_model(input beat_t beats[$], output logic [31:0] pkt[$],
                                       output int unsigned n_err, output bit has_pkt);
      bit open = 1'b0, dropping = 1'b0;
      logic [31:0] cur[$];
      pkt.delete(); n_err = 0; has_pkt = 1'b0;
      foreach (beats[i]) begin
         if (dropping) begin
            if (beats[i].eop) dropping = 1'b0;
            continue;
         end
         if (beats[i].sop) begin
            if (open) n_err++;
            cur.delete(); cur.push_back(beats[i].data); open = 1'b1;
         end else if (!open) begin
            continue;
         end else begin
            cur.push_back(beats[i].data);
         end
         if (beats[i].eop) begin
            pkt = cur; has_pkt = 1'b1; open = 1'b0;
         end else if (cur.size() == MAX_PKT_DW) begin
            n_err++; open = 1'b0; dropping = 1'b1;
         end
      end
   endfunction

   // AVMM slave + bus monitor: drives slave inputs just after posedge, samples at negedge.
   logic        prev_stall = 1'b0;
   logic [1:0]  prev_ctl;
   logic [17:0] prev_addr;
   logic [31:0] prev_data;
   initial begin
      bus.m_waitrequest = 1'b0; bus.m_readdatavalid = 1'b0; bus.m_readdata = '0;
      forever begin
         @(posedge clk); #1;
         cyc++;
         bus.m_waitrequest = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
         if (rsp_q.size() != 0 && rsp_q[0] == cyc) begin
            void'(rsp_q.pop_front());
            bus.m_readdatavalid = 1'b1;
            bus.m_readdata = (fcr_q.size() != 0) ? fcr_q.pop_front() : fcr_default;
            rdv_log.push_back(cyc);
         end else begin
            bus.m_readdatavalid = 1'b0;
            bus.m_readdata = $urandom;
         end
         @(negedge clk);
         if (rst_n) begin
            if (bus.m_read || bus.m_write)
               check("rd_wr_exclusive", 32'(bus.m_read & bus.m_write), 32'd0);
            if (prev_stall) begin
               check("stall_ctl", 32'({bus.m_read, bus.m_write}), 32'(prev_ctl));
               check("stall_addr", 32'(bus.m_address), 32'(prev_addr));
               check("stall_data", bus.m_writedata, prev_data);
            end
            prev_stall = (bus.m_read || bus.m_write) && bus.m_waitrequest;
            prev_ctl   = {bus.m_read, bus.m_write};
            prev_addr  = bus.m_address;
            prev_data  = bus.m_writedata;
            if (bus.m_read && !bus.m_waitrequest) begin
               rd_log.push_back(cyc);
               rsp_q.push_back(cyc + 2);
            end
            if (bus.m_write && !bus.m_waitrequest)
               wr_log.push_back('{bus.m_address, bus.m_writedata, cyc});
            if (pkt_done) begin done_n++; done_cyc = cyc; end
            if (err_timeout) tmo_n++;
            if (err_len) begin len_n++; len_cyc = cyc; end
         end else begin
            prev_stall = 1'b0;
         end
      end
   end

   task automatic send_beat(input logic [31:0] d, input bit sop, input bit eop,
                            output int unsigned acc);
      @(posedge clk); #2;
      bus.s_valid = 1'b1; bus.s_data = d; bus.s_sop = sop; bus.s_eop = eop;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (bus.s_ready) break;
      end
      if (!bus.s_ready) check("s_ready_wait", 32'(bus.s_ready), 32'd1);
      acc = cyc;
   endtask

   task automatic idle_bus();
      @(posedge clk); #2;
      bus.s_valid = 1'b0; bus.s_sop = 1'b0; bus.s_eop = 1'b0;
   endtask

   task automatic wait_event(input string tag, input int unsigned budget);
      int unsigned b0 = done_n + tmo_n;
      for (int unsigned n = 0; n < budget && done_n + tmo_n == b0; n++) begin
         @(negedge clk); #1;
      end
      check({tag, "_event"}, done_n + tmo_n - b0, 32'd1);
   endtask

   task automatic add_beat(input logic [31:0] d, input bit sop, input bit eop);
      stim.push_back('{d, sop, eop});
   endtask

   task automatic add_pkt(input int unsigned n, input bit rnd);
      for (int unsigned i = 0; i < n; i++)
         add_beat(rnd ? $urandom : (i + 1) * 32'h11, i == 0, i == n - 1);
   endtask

   task automatic run_stream(input string tag);
      logic [31:0] fv[$];
      logic [31:0] pkt[$];
      int unsigned n_err, base_done, base_len, eop_cyc, polls, c;
      bit has;
      fv = fcr_q;
      wr_log.delete(); rd_log.delete(); rdv_log.delete(); acc_log.delete();
      base_done = done_n; base_len = len_n; c = 0;
      foreach (stim[i]) begin
         send_beat(stim[i].data, stim[i].sop, stim[i].eop, c);
         acc_log.push_back(c);
      end
      eop_cyc = c;
      idle_bus();
      frame_model(stim, pkt, n_err, has);
      exp_drop += n_err;
      if (has) begin
         exp_pkt++;
         polls = 1;
         foreach (fv[i]) begin
            if (fv[i][15:0] >= pkt.size()) break;
            polls++;
         end
         wait_event(tag, 6000);
         check({tag, "_done_cnt"}, done_n - base_done, 32'd1);
         check({tag, "_wr_cnt"}, wr_log.size(), pkt.size() + 1);
         if (wr_log.size() == pkt.size() + 1) begin
            foreach (pkt[i]) begin
               check({tag, "_dr_addr"}, 32'(wr_log[i].addr), 32'(DR));
               check({tag, "_dr_data"}, wr_log[i].data, pkt[i]);
            end
            check({tag, "_commit_addr"}, 32'(wr_log[pkt.size()].addr), 32'(FCR));
            check({tag, "_commit_data"}, wr_log[pkt.size()].data, 32'h8000_0000 + pkt.size());
         end
         check({tag, "_polls"}, rd_log.size(), polls);
         if (!stall_en && rd_log.size() == polls && rdv_log.size() == polls
             && wr_log.size() == pkt.size() + 1) begin
            check({tag, "_rd_lat"}, rd_log[0], eop_cyc + 1);
            for (int unsigned i = 1; i < polls; i++)
               check({tag, "_poll_gap"}, rd_log[i], rdv_log[i-1] + POLL_GAP + 1);
            check({tag, "_wr_lat"}, wr_log[0].cyc, rdv_log[polls-1] + 1);
            for (int unsigned i = 1; i < wr_log.size(); i++)
               check({tag, "_wr_b2b"}, wr_log[i].cyc, wr_log[i-1].cyc + 1);
            check({tag, "_done_cyc"}, done_cyc, wr_log[pkt.size()].cyc);
         end
         @(negedge clk);
      end else begin
         repeat (8) @(negedge clk);
         check({tag, "_no_rd"}, rd_log.size(), 32'd0);
         check({tag, "_no_wr"}, wr_log.size(), 32'd0);
      end
      check({tag, "_err_len"}, len_n - base_len, n_err);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_pkt_count"}, 32'(pkt_count), 32'(stat(exp_pkt)));
      check({tag, "_drop_count"}, 32'(drop_count), 32'(stat(exp_drop)));
      fcr_q.delete();
      stim.delete();
   endtask

   initial begin
      int unsigned c, n, b_len, b_done;
      bus.s_valid = 1'b0; bus.s_sop = 1'b0; bus.s_eop = 1'b0; bus.s_data = '0;
      repeat (3) @(negedge clk);
      check("rst_s_ready", 32'(bus.s_ready), 32'd0);
      check("rst_m_read", 32'(bus.m_read), 32'd0);
      check("rst_m_write", 32'(bus.m_write), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_pulses", 32'({pkt_done, err_timeout, err_len}), 32'd0);
      check("rst_counts", 32'({pkt_count, drop_count}), 32'd0);
      @(posedge clk); #2 rst_n = 1'b1;
      @(negedge clk);
      check("ready_first_cyc", 32'(bus.s_ready), 32'd0);
      @(negedge clk);
      check("ready_second_cyc", 32'(bus.s_ready), 32'd1);

      add_pkt(4, 1'b0); fcr_q = '{32'h40};
      run_stream("pkt4");

      add_beat(32'hABCD, 1'b1, 1'b1); fcr_q = '{32'h1};
      run_stream("single");

      add_pkt(8, 1'b1); fcr_q = '{32'h4, 32'h4, 32'h10};
      run_stream("pkt8_poll");

      // Timeout: FCR never reports free space.
      fcr_default = 32'h0;
      wr_log.delete(); rd_log.delete(); rdv_log.delete();
      b_len = tmo_n;
      for (int unsigned i = 0; i < 3; i++) send_beat($urandom, i == 0, i == 2, c);
      idle_bus();
      wait_event("tmo", 8000);
      @(negedge clk);
      check("tmo_ready_next", 32'(bus.s_ready), 32'd1);
      check("tmo_pulse", tmo_n - b_len, 32'd1);
      check("tmo_polls", rd_log.size(), TIMEOUT_POLLS);
      check("tmo_no_wr", wr_log.size(), 32'd0);
      exp_drop++;
      check("tmo_drop_count", 32'(drop_count), 32'(stat(exp_drop)));
      fcr_default = 32'h0000_FFFF;

      add_pkt(70, 1'b1);
      run_stream("long70");
      if (acc_log.size() >= 64) check("long_err_cyc", len_cyc, acc_log[63]);
      add_pkt(5, 1'b1); fcr_q = '{32'h5};
      run_stream("after_long");

      add_beat(32'hDEAD, 1'b0, 1'b0);
      add_pkt(3, 1'b1); stim[3].eop = 1'b0;
      add_pkt(3, 1'b1);
      run_stream("sop_restart");

      for (int k = 0; k < 4; k++) begin
         n = $urandom_range(1, 20);
         add_pkt(n, 1'b1);
         fcr_q = '{32'($urandom_range(0, n + 2)), 32'h0000_FFFF};
         run_stream("rand");
      end

      stall_en = 1'b1;
      add_pkt($urandom_range(16, 64), 1'b1);
      run_stream("stall");
      stall_en = 1'b0;

      // Reset while a packet is still being collected.
      b_len = len_n; b_done = done_n;
      send_beat($urandom, 1'b1, 1'b0, c);
      send_beat($urandom, 1'b0, 1'b0, c);
      idle_bus();
      @(posedge clk); #2 rst_n = 1'b0;
      @(negedge clk);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_ready", 32'(bus.s_ready), 32'd0);
      check("midrst_counts", 32'({pkt_count, drop_count}), 32'd0);
      repeat (2) @(negedge clk);
      @(posedge clk); #2 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("midrst_no_pulses", (len_n - b_len) + (done_n - b_done), 32'd0);
      exp_pkt = 0; exp_drop = 0;
      add_pkt(6, 1'b1);
      run_stream("post_reset");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/pmci_vdm_tx_sequencer.md
# pmci_vdm_tx_sequencer

Buffers one outbound PCIe VDM (MCTP) packet from an internal AXI-style stream and sequences its transmission through the PMCI VDM TX mailbox: poll the VDM FIFO control register for free space, write each dword to the TX data register, then issue a commit. Sits between the MCTP packet source and the AVMM host-side CSR fabric that reaches the PMCI/ST2MM VDM register window.

## Interface
- DATA_W, 32, stream and AVMM data width
- ADDR_W, 18, AVMM byte address width
- FCR_ADDR, 18'h2000, VDM FIFO control register offset
- DR_ADDR, 18'h2008, VDM TX data register offset
- MAX_PKT_DW, 64, packet buffer depth in dwords (power of 2)
- POLL_GAP, 16, idle cycles between FCR polls
- TIMEOUT_POLLS, 256, polls before abandoning a packet
- clk  in  1  sole clock
- rst_n  in  1  asynchronous active-low reset
- s_valid / s_ready  in / out  1  stream handshake
- s_data  in  DATA_W  packet dword
- s_sop / s_eop  in  1  first / last dword markers
- m_address  out  ADDR_W;  m_write, m_read  out  1;  m_writedata  out  DATA_W
- m_readdata  in  DATA_W;  m_readdatavalid, m_waitrequest  in  1
- busy  out  1  packet in flight (not IDLE)
- pkt_done, err_timeout, err_len  out  1  single-cycle event pulses
- pkt_count, drop_count  out  16  statistics

## Operation
- FCR read: bits[15:0] = TX FIFO free dwords. FCR write: bit31 = commit, bits[15:0] = packet length in dwords.
- States: IDLE, COLLECT, DROP, POLL_RD, POLL_WAIT, GAP, WR_DATA, COMMIT.
- IDLE: s_ready=1. Beat with s_sop: store, len=1; if s_eop also, go POLL_RD, else COLLECT. Beat without s_sop: discarded silently.
- COLLECT: s_ready=1; store beat, len++. s_eop → POLL_RD. Beat with s_sop while len>0: discard prior words, restart with this beat, pulse err_len, drop_count++. Storing word number MAX_PKT_DW without s_eop → err_len pulse, drop_count++, go DROP.
- DROP: s_ready=1, discard until s_eop beat accepted → IDLE.
- POLL_RD: m_read=1, m_address=FCR_ADDR, held until m_waitrequest=0 → POLL_WAIT.
- POLL_WAIT: on m_readdatavalid: free>=len → WR_DATA (rd pointer 0); else poll_cnt++, and if poll_cnt reaches TIMEOUT_POLLS → err_timeout, drop_count++, IDLE; else GAP.
- GAP: count POLL_GAP cycles → POLL_RD.
- WR_DATA: m_write=1, m_address=DR_ADDR, m_writedata=buffer[rd]; advance rd on each cycle m_waitrequest=0; after word len-1 accepted → COMMIT.
- COMMIT: m_write=1, m_address=FCR_ADDR, m_writedata={1'b1,15'b0,len[15:0]}; on acceptance pulse pkt_done, pkt_count++, → IDLE.
- s_ready=0 in POLL_RD through COMMIT; never m_read and m_write together.
- Counters saturate at 16'hFFFF.

## Timing
- Reset: all outputs 0, state IDLE; s_ready rises first cycle after rst_n deasserts. Reset mid-packet discards buffer, no pulses.
- eop accepted cycle N → m_read asserted N+1.
- readdatavalid with enough space cycle N → first m_write N+1; back-to-back data one dword/cycle when waitrequest low; commit cycle after last data accepted; pkt_done same cycle commit accepted.
- Insufficient space: next m_read at readdatavalid cycle + POLL_GAP + 1.
- Buffer read is registered-ahead: m_writedata valid same cycle m_write asserts.
- m_address/m_writedata/m_write/m_read stable while m_waitrequest=1.

## Configuration
- PMCI_VDM_TX_SEQ_STATS_EN defined: pkt_count and drop_count implemented. Undefined: both tied to 0, counter logic removed; pulses unaffected.

## Structure
- Package pmci_vdm_seq_pkg: state enum, FCR_COMMIT_BIT=31, FCR_LEN_LSB/MSB=0/15, default FCR/DR offsets.
- Sub-module pmci_vdm_pkt_buf: MAX_PKT_DW×DATA_W simple dual-port buffer with write pointer, read pointer and registered read; sequencer owns the state machine and AVMM master.

## Test plan
- 4-dword packet 0x11..0x44, FCR returns 0x40 → DR writes 0x11,0x22,0x33,0x44, FCR write 0x8000_0004, pkt_done, pkt_count=1.
- Single beat sop+eop 0xABCD, FCR 0x1 → one DR write, commit 0x8000_0001.
- 8-dword packet, FCR returns 0x4 twice then 0x10 → 3 reads spaced POLL_GAP+1 after each readdatavalid, then 8 writes, commit 0x8000_0008.
- FCR always 0 → exactly TIMEOUT_POLLS reads, err_timeout pulse, no DR writes, drop_count=1, s_ready high next cycle.
- 70-beat packet (MAX_PKT_DW=64) → err_len at beat 64, remaining beats accepted, no AVMM traffic; next valid packet transmits correctly.
- m_waitrequest randomly high 50% during WR_DATA → data order and commit value unchanged; signals stable while stalled.
